fmap_window_gen: RTL and testbench

Upstream feature-map streamer for the weight-stationary systolic array. Reads one IMG_H x IMG_W feature map from the fmap BRAM in raster order and uses two line buffers to form 3x3 sliding windows (valid convolution, stride 1). It replays the map once per filter, for N_FILTER passes. At the end of each pass it pulses fmap_finish, which advances the weight buffer's filter_count.

---
 rtl/fmap_window_gen_if.sv | 33 +++
 rtl/fmap_window_gen.sv | 174 +++++++++++++++++
 tb/tb_fmap_window_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fmap_window_gen_if.sv
// Interface between the feature-map window generator and its environment.
// Bundles the start request, the fmap BRAM read port and the window/pass
// status outputs.
//   slave  : the window generator side (drives address, windows, status)
//   master : the controller/BRAM side (drives start and read data)
interface fmap_window_gen_if #(
  parameter int M      = 8,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] fmap_addr;
  logic [M-1:0]      fmap_rdata;
  logic [9*M-1:0]    win_data;
  logic              win_valid;
  logic [7:0]        out_row;
  logic [7:0]        out_col;
  logic              fmap_finish;
  logic [7:0]        pass_idx;
  logic              busy;
  logic              all_done;

  modport slave (
    input  start, fmap_rdata,
    output fmap_addr, win_data, win_valid, out_row, out_col,
           fmap_finish, pass_idx, busy, all_done
  );

  modport master (
    output start, fmap_rdata,
    input  fmap_addr, win_data, win_valid, out_row, out_col,
           fmap_finish, pass_idx, busy, all_done
  );
endinterface

// File: rtl/fmap_window_gen.sv
// Feature-map 3x3 window generator.
// Streams an IMG_H x IMG_W map out of the fmap BRAM in raster order, builds
// 3x3 windows (valid convolution, stride 1) with two line buffers, and
// replays the map N_FILTER times, pulsing fmap_finish at the end of each pass.
// Ports:
//   clk    : clock
//   Rst_n  : asynchronous active-low reset
//   bus    : fmap_window_gen_if.slave
//            start (in), fmap_rdata (in), fmap_addr, win_data, win_valid,
//            out_row, out_col, fmap_finish, pass_idx, busy, all_done (out)
module fmap_window_gen #(
  parameter int M        = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int ADDR_W   = 10,
  parameter int N_FILTER = 8
) (
  input  logic             clk,
  input  logic             Rst_n,
  fmap_window_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, GAP} state_t;

  localparam int         COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0] LAST_COL  = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_ROW  = 8'(IMG_H - 1);
  localparam logic [7:0] LAST_PASS = 8'(N_FILTER - 1);

  state_t            state_reg, state_next;
  logic              cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        in_row_reg, in_col_reg;
  logic [7:0]        pass_idx_reg;
  logic              run_last;

  // read-return tracking (one cycle behind the address)
  logic              rd_valid_reg;
  logic [7:0]        rd_row_reg, rd_col_reg;
  logic [COL_W-1:0]  lb_idx;
  logic              rd_win_ok;

  logic [M-1:0]      lb0_reg [0:IMG_W-1];   // previous row
  logic [M-1:0]      lb1_reg [0:IMG_W-1];   // row before that
  logic [M-1:0]      win_px_reg [0:2][0:2]; // [column][row], column 2 newest
  logic              win_valid_reg;
  logic [7:0]        out_row_reg, out_col_reg;

  logic              busy_c, finish_c, all_done_c;

  assign run_last = (state_reg == RUN) && (in_row_reg == LAST_ROW) &&
                    (in_col_reg == LAST_COL);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (bus.start) state_next = RUN;
      RUN:    if (run_last)  state_next = DRAIN;
      DRAIN:  if (cnt_reg)   state_next = FINISH;
      // pass_idx has already advanced here; having wrapped to 0 means the
      // pass that just ended was the last one
      FINISH: state_next = (pass_idx_reg == 8'd0) ? IDLE : GAP;
      GAP:    if (cnt_reg)   state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_c     = (state_reg != IDLE);
    finish_c   = (state_reg == FINISH);
    all_done_c = (state_reg == FINISH) && (pass_idx_reg == 8'd0);
  end

  // ---------------- address generation and pass counting ----------------
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg      <= 1'b0;
      addr_reg     <= '0;
      in_row_reg   <= 8'd0;
      in_col_reg   <= 8'd0;
      pass_idx_reg <= 8'd0;
      rd_valid_reg <= 1'b0;
      rd_row_reg   <= 8'd0;
      rd_col_reg   <= 8'd0;
    end else begin
      // two-cycle phase counter for DRAIN and GAP, restarted on every change
      cnt_reg <= (state_next != state_reg) ? 1'b0 : ~cnt_reg;

      if (state_next == RUN && state_reg != RUN) begin
        addr_reg   <= '0;
        in_row_reg <= 8'd0;
        in_col_reg <= 8'd0;
      end else if (state_reg == RUN && state_next == RUN) begin
        addr_reg <= addr_reg + ADDR_W'(1);
        if (in_col_reg == LAST_COL) begin
          in_col_reg <= 8'd0;
          in_row_reg <= in_row_reg + 8'd1;
        end else begin
          in_col_reg <= in_col_reg + 8'd1;
        end
      end

      if (state_reg == DRAIN && state_next == FINISH)
        pass_idx_reg <= (pass_idx_reg == LAST_PASS) ? 8'd0 : pass_idx_reg + 8'd1;

      rd_valid_reg <= (state_reg == RUN);
      rd_row_reg   <= in_row_reg;
      rd_col_reg   <= in_col_reg;
    end
  end

  assign lb_idx    = rd_col_reg[COL_W-1:0];
  // columns 0/1 of a row would pair with stale columns of the prior row
  assign rd_win_ok = rd_valid_reg && (rd_row_reg >= 8'd2) && (rd_col_reg >= 8'd2);

  // ---------------- line buffers and window ----------------
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_reg[i] <= '0;
        lb1_reg[i] <= '0;
      end
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++)
          win_px_reg[j][i] <= '0;
      win_valid_reg <= 1'b0;
      out_row_reg   <= 8'd0;
      out_col_reg   <= 8'd0;
    end else begin
      win_valid_reg <= rd_win_ok;
      if (rd_valid_reg) begin
        for (int j = 0; j < 2; j++)
          for (int i = 0; i < 3; i++)
            win_px_reg[j][i] <= win_px_reg[j+1][i];
        win_px_reg[2][0] <= lb1_reg[lb_idx];
        win_px_reg[2][1] <= lb0_reg[lb_idx];
        win_px_reg[2][2] <= bus.fmap_rdata;
        lb1_reg[lb_idx]  <= lb0_reg[lb_idx];
        lb0_reg[lb_idx]  <= bus.fmap_rdata;
        if (rd_win_ok) begin
          out_row_reg <= rd_row_reg - 8'd2;
          out_col_reg <= rd_col_reg - 8'd2;
        end
      end
    end
  end

  // row-major packing, X00 in the top slice
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
        assign bus.win_data[(8 - (gi*3 + gj))*M +: M] = win_px_reg[gj][gi];
      end
    end
  endgenerate

  assign bus.fmap_addr   = addr_reg;
  assign bus.win_valid   = win_valid_reg;
  assign bus.out_row     = out_row_reg;
  assign bus.out_col     = out_col_reg;
  assign bus.pass_idx    = pass_idx_reg;
  assign bus.fmap_finish = finish_c;
  assign bus.all_done    = all_done_c;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_fmap_window_gen.sv
// Testbench for fmap_window_gen: 5x5 map, 2 passes. A per-cycle reference
// model derives every expected output from the start cycle and the map
// contents with plain arithmetic.
module tb_fmap_window_gen;
  localparam int M      = 8;
  localparam int W      = 5;
  localparam int H      = 5;
  localparam int ADDR_W = 10;
  localparam int N      = 2;
  localparam int NPIX   = W * H;
  localparam int P      = NPIX + 5;                 // pass period
  localparam int LAST_U = (N - 1) * P + NPIX + 2;   // offset of final FINISH
  localparam int NWIN   = N * (H - 2) * (W - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmap_window_gen_if #(.M(M), .ADDR_W(ADDR_W)) bus_if();

  fmap_window_gen #(.M(M), .IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .N_FILTER(N)) dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus_if)
  );

  // fmap BRAM: registered read, data one cycle after the address
  logic [M-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus_if.fmap_rdata <= mem[bus_if.fmap_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int s       = 0;   // cycle in which the accepted start was high
  bit active  = 0;
  bit ran     = 0;   // a run was accepted since the last reset
  int win_cnt = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [9*M-1:0] exp_win(int r, int c);
    logic [9*M-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i*3 + j))*M +: M] = mem[(r + i)*W + c + j];
    return w;
  endfunction

  // ---------------- per-cycle reference check ----------------
  always @(negedge clk) begin
    int u, pass, ph, a, rr, cc;
    bit in_run, e_busy, e_valid, e_fin, e_done;
    logic [7:0] e_pidx;
    if (!rst_n) begin
      check_val("rst_busy", bus_if.busy, 0);
      check_val("rst_valid", bus_if.win_valid, 0);
      check_val("rst_finish", bus_if.fmap_finish, 0);
      check_val("rst_done", bus_if.all_done, 0);
      check_val("rst_pass", bus_if.pass_idx, 0);
      check_val("rst_addr", bus_if.fmap_addr, 0);
      check_val("rst_row", bus_if.out_row, 0);
      check_val("rst_col", bus_if.out_col, 0);
      check_val("rst_win", bus_if.win_data, 0);
    end else begin
      e_busy = 0; e_valid = 0; e_fin = 0; e_done = 0; e_pidx = 8'd0;
      in_run = 0; ph = 0; rr = 0; cc = 0;
      if (active && cyc > s) begin
        u = cyc - s - 1;
        pass = u / P;
        ph = u % P;
        if (u <= LAST_U) begin
          e_busy = 1;
          in_run = (ph < NPIX);
          e_fin  = (ph == NPIX + 2);
          e_done = e_fin && (pass == N - 1);
          e_pidx = 8'((ph >= NPIX + 2) ? (pass + 1) % N : pass);
          a = ph - 2;  // pixel whose address went out two cycles ago
          if (a >= 0 && a < NPIX && a / W >= 2 && a % W >= 2) begin
            e_valid = 1;
            rr = a / W - 2;
            cc = a % W - 2;
          end
        end
      end
      check_val("busy", bus_if.busy, e_busy);
      check_val("win_valid", bus_if.win_valid, e_valid);
      check_val("fmap_finish", bus_if.fmap_finish, e_fin);
      check_val("all_done", bus_if.all_done, e_done);
      check_val("pass_idx", bus_if.pass_idx, e_pidx);
      if (in_run)
        check_val("fmap_addr", bus_if.fmap_addr, ph);
      else if (!ran)
        check_val("addr_idle", bus_if.fmap_addr, 0);
      if (e_valid) begin
        check_val("win_data", bus_if.win_data, exp_win(rr, cc));
        check_val("out_row", bus_if.out_row, rr);
        check_val("out_col", bus_if.out_col, cc);
      end
      if (bus_if.win_valid) win_cnt++;
      if (e_fin)
        $display("pass end: cyc=%0d pass_idx=%0d all_done=%0d", cyc, bus_if.pass_idx, bus_if.all_done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit accept);
    bus_if.start = 1'b1;
    if (accept) begin
      s = cyc; active = 1; ran = 1; win_cnt = 0;
      $display("start accepted: cyc=%0d", cyc);
    end else begin
      $display("start while busy: cyc=%0d", cyc);
    end
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) mem[i] = M'($urandom);
  endtask

  task automatic run_full(input int n_ignored);
    int t0;
    pulse_start(1);
    t0 = s;
    for (int k = 0; k < n_ignored; k++) begin
      to_cycle(t0 + 2 + int'($urandom_range(0, LAST_U / 2)) + k * (LAST_U / 2));
      if (cyc <= t0 + LAST_U + 1) pulse_start(0);
    end
    to_cycle(t0 + N * P - 1);
    check_val("win_count", win_cnt, NWIN);
  endtask

  initial begin
    bus_if.start = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    for (int i = 0; i < NPIX; i++) mem[i] = M'(i);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    to_cycle(cyc + 2);

    // run A: identity map; starts during RUN and in the final FINISH ignored
    pulse_start(1);
    to_cycle(s + 10);
    pulse_start(0);
    to_cycle(s + LAST_U + 1);
    pulse_start(0);
    check_val("win_count", win_cnt, NWIN);
    fill_random();

    // run B starts two cycles after the final FINISH
    to_cycle(s + N * P);
    run_full(2);

    // run C: aborted by reset mid-pass, then a clean run D
    to_cycle(cyc + 3);
    fill_random();
    pulse_start(1);
    to_cycle(s + 20);
    rst_n = 1'b0;
    active = 0;
    ran = 0;
    $display("reset asserted: cyc=%0d", cyc);
    to_cycle(cyc + 2);
    rst_n = 1'b1;
    to_cycle(cyc + 2);
    run_full(0);

    // a few more randomized runs with random idle gaps
    for (int k = 0; k < 3; k++) begin
      to_cycle(cyc + 1 + int'($urandom_range(0, 6)));
      fill_random();
      run_full(int'($urandom_range(0, 2)));
    end

    to_cycle(cyc + 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
